// File: rtl/slavespi_mb.sv
`timescale 1ns/1ps
// slavespi_mb: AVR-facing SPI slave in the fclk domain.
//   Register-number phase (cs high) collects a register number; data phase
//   (cs low) transfers bytes to/from a window of NREGS config registers with
//   address auto-increment, or to a stream FIFO (valid/ready) with overflow
//   tracking, or to the stream control/status register.
// Ports:
//   fclk, rst_n           system clock, async active-low reset
//   spics_n/spick/spido   AVR SPI chip select, clock, MOSI (asynchronous)
//   spidi                 AVR MISO (shift register bit 0)
//   status_in             byte returned during the register-number phase
//   cfg_out/cfg_stb       config registers (reg k at [8k+7:8k]) and write pulses
//   st_data/st_valid      FIFO head byte and not-empty flag
//   st_ready              fabric pop request
//   st_level/st_ovf       FIFO occupancy and sticky overflow flag
module slavespi_mb #(
  parameter int         NREGS     = 8,
  parameter logic [7:0] REGBASE   = 8'h50,
  parameter logic [7:0] STREAMREG = 8'h70,
  parameter int         FIFO_AW   = 4
) (
  input  logic                 fclk,
  input  logic                 rst_n,
  input  logic                 spics_n,
  input  logic                 spick,
  input  logic                 spido,
  output logic                 spidi,
  input  logic [7:0]           status_in,
  output logic [8*NREGS-1:0]   cfg_out,
  output logic [NREGS-1:0]     cfg_stb,
  output logic [7:0]           st_data,
  output logic                 st_valid,
  input  logic                 st_ready,
  output logic [FIFO_AW:0]     st_level,
  output logic                 st_ovf
);
  localparam int         PW      = FIFO_AW + 1;
  localparam int         DEPTH   = 1 << FIFO_AW;
  localparam logic [8:0] NREGS9  = 9'(NREGS);
  localparam logic [8:0] DEPTH9  = 9'(DEPTH);
  localparam logic [7:0] CTRLREG = STREAMREG + 8'd1;

  logic [2:0]              cs_sync_q, sck_sync_q, sdo_sync_q;
  logic [7:0]              regnum_q, regnum_d, addr_q, addr_d;
  logic [7:0]              rx_q, rx_d, shift_q, shift_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [NREGS-1:0][7:0]   cfg_q, cfg_d;
  logic [NREGS-1:0]        stb_pend_q, stb_pend_d, cfg_stb_q;
  logic [DEPTH-1:0][7:0]   mem_q, mem_d;
  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic [7:0]              st_data_q, st_data_d;
  logic                    st_valid_q, ovf_q, ovf_d;

  logic       cs_rise_s, cs_fall_s, sck_rise_s, sdo_s;
  logic       reg_edge_s, data_edge_s, byte_done_s;
  logic [7:0] rx_full_s, off_s;
  logic       in_win_s, is_stream_s, is_ctrl_s;
  logic       wr_en_s, push_s, ctrl_s, flush_s, ovf_clr_s;
  logic       full_s, pop_s, push_ok_s, push_rej_s;

  // Byte presented on MISO for a given working address.
  function automatic logic [7:0] readback(input logic [7:0] a,
                                          input logic [NREGS-1:0][7:0] regs,
                                          input logic [PW-1:0] lvl,
                                          input logic ovf);
    logic [7:0] off;
    logic [8:0] free;
    logic [7:0] rb;
    off  = a - REGBASE;
    free = DEPTH9 - 9'(lvl);
    rb   = 8'hFF;
    if ({1'b0, off} < NREGS9) begin
      for (int k = 0; k < NREGS; k++) begin
        rb = (off == 8'(k)) ? regs[k] : rb;
      end
    end else if (a == STREAMREG) begin
      rb = (free > 9'd255) ? 8'hFF : free[7:0];
    end else if (a == CTRLREG) begin
      rb = {ovf, 2'b00, 5'(lvl)};
    end else begin
      rb = 8'hFF;
    end
    return rb;
  endfunction

  // Edges are taken from the two oldest synchroniser stages.
  assign cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];
  assign sck_rise_s  = sck_sync_q[1] & ~sck_sync_q[2];
  assign sdo_s       = sdo_sync_q[2];
  // sck edges coinciding with a cs transition belong to neither phase.
  assign reg_edge_s  = sck_rise_s & cs_sync_q[2] & cs_sync_q[1];
  assign data_edge_s = sck_rise_s & ~cs_sync_q[2] & ~cs_sync_q[1];
  assign byte_done_s = data_edge_s & (cnt_q == 3'd7);
  assign rx_full_s   = {sdo_s, rx_q[7:1]};

  // off_s wraps for addresses below REGBASE, so one compare covers the window.
  assign off_s       = addr_q - REGBASE;
  assign in_win_s    = ({1'b0, off_s} < NREGS9);
  assign is_stream_s = (addr_q == STREAMREG);
  assign is_ctrl_s   = (addr_q == CTRLREG);
  assign wr_en_s     = byte_done_s & in_win_s;
  assign push_s      = byte_done_s & ~in_win_s & is_stream_s;
  assign ctrl_s      = byte_done_s & ~in_win_s & ~is_stream_s & is_ctrl_s;
  assign flush_s     = ctrl_s & rx_full_s[0];
  assign ovf_clr_s   = ctrl_s & rx_full_s[1];

  assign full_s      = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                       (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop_s       = st_valid_q & st_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok_s   = push_s & (~full_s | pop_s);
  assign push_rej_s  = push_s & ~push_ok_s;

  // Next-state logic for the SPI engine, config window and FIFO.
  always_comb begin
    if (cs_rise_s) regnum_d = 8'h00;
    else if (reg_edge_s) regnum_d = {sdo_s, regnum_q[7:1]};
    else regnum_d = regnum_q;

    if (cs_fall_s) cnt_d = 3'd0;
    else if (data_edge_s) cnt_d = cnt_q + 3'd1;
    else cnt_d = cnt_q;

    if (data_edge_s) rx_d = rx_full_s;
    else rx_d = rx_q;

    if (cs_fall_s) addr_d = regnum_q;
    else if (byte_done_s && (in_win_s || !(is_stream_s || is_ctrl_s))) addr_d = addr_q + 8'd1;
    else addr_d = addr_q;

    for (int k = 0; k < NREGS; k++) begin
      cfg_d[k]      = (wr_en_s && (off_s == 8'(k))) ? rx_full_s : cfg_q[k];
      stb_pend_d[k] = wr_en_s && (off_s == 8'(k));
    end

    // Flush wins: both pointers collapse onto the write pointer.
    if (flush_s) begin
      wptr_d = wptr_q;
      rptr_d = wptr_q;
    end else begin
      wptr_d = wptr_q + PW'(push_ok_s);
      rptr_d = rptr_q + PW'(pop_s);
    end
    level_d = wptr_d - rptr_d;

    mem_d = mem_q;
    if (push_ok_s && !flush_s) mem_d[wptr_q[FIFO_AW-1:0]] = rx_full_s;
    else mem_d = mem_q;
    st_data_d = mem_d[rptr_d[FIFO_AW-1:0]];

    // An overflow in the same cycle as a clear keeps the flag set.
    if (push_rej_s) ovf_d = 1'b1;
    else if (ovf_clr_s) ovf_d = 1'b0;
    else ovf_d = ovf_q;

    if (cs_rise_s) shift_d = status_in;
    else if (cs_fall_s || byte_done_s) shift_d = readback(addr_d, cfg_q, level_d, ovf_d);
    else if (reg_edge_s || data_edge_s) shift_d = {1'b0, shift_q[7:1]};
    else shift_d = shift_q;
  end

  // State registers; cs sync resets high and sck low so reset creates no edge.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= 3'b111;
      sck_sync_q <= 3'b000;
      sdo_sync_q <= 3'b000;
      regnum_q   <= 8'h00;
      addr_q     <= 8'h00;
      rx_q       <= 8'h00;
      shift_q    <= 8'h00;
      cnt_q      <= 3'd0;
      cfg_q      <= '0;
      stb_pend_q <= '0;
      cfg_stb_q  <= '0;
      mem_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      st_data_q  <= 8'h00;
      st_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[1:0], spics_n};
      sck_sync_q <= {sck_sync_q[1:0], spick};
      sdo_sync_q <= {sdo_sync_q[1:0], spido};
      regnum_q   <= regnum_d;
      addr_q     <= addr_d;
      rx_q       <= rx_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      stb_pend_q <= stb_pend_d;
      cfg_stb_q  <= stb_pend_q;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      st_data_q  <= st_data_d;
      st_valid_q <= (level_d != '0);
      ovf_q      <= ovf_d;
    end
  end

  assign spidi    = shift_q[0];
  assign cfg_out  = cfg_q;
  assign cfg_stb  = cfg_stb_q;
  assign st_data  = st_data_q;
  assign st_valid = st_valid_q;
  assign st_level = level_q;
  assign st_ovf   = ovf_q;
endmodule
